// File: rtl/des_key_sched_pkg.sv
// rtl/des_key_sched_pkg.sv - DES key-schedule constants, permutation tables and rotate helpers
package des_key_sched_pkg;

  localparam int NROUNDS  = 16;
  localparam int ROUND_W  = 5;
  localparam int KEY_W    = 64;
  localparam int SUBKEY_W = 48;
  localparam int HALF_W   = 28;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Tables use DES bit numbering: bit 1 is the MSB of the source vector.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [KEY_W-1:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) begin
      o[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    end
    return o;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// rtl/des_key_sched_if.sv - start/key request and subkey stream between round datapath and key schedule
interface des_key_sched_if;
  import des_key_sched_pkg::*;

  logic                start;
  logic                decrypt;
  logic [KEY_W-1:0]    key;
  logic [SUBKEY_W-1:0] subkey;
  logic [ROUND_W-1:0]  round;
  logic                key_valid;
  logic                done;
  logic                busy;

  modport master (
    output start, decrypt, key,
    input  subkey, round, key_valid, done, busy
  );

  modport slave (
    input  start, decrypt, key,
    output subkey, round, key_valid, done, busy
  );

endinterface

// File: rtl/des_key_sched_pc2.sv
// rtl/des_key_sched_pc2.sv - combinational PC-2 compression of C||D (56 bits) to a 48-bit subkey
module des_pc2
  import des_key_sched_pkg::*;
(
  input  logic [55:0]         cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - iterative DES round-key generator, one subkey per clock in either direction
module des_key_sched
  import des_key_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  des_key_sched_if.slave bus
);

  state_t state, state_nxt;

  logic [HALF_W-1:0]   c_q, d_q;
  logic [HALF_W-1:0]   c_src, d_src, c_nxt, d_nxt;
  logic                dir_q, dir_src;
  logic [3:0]          rcnt;
  logic [1:0]          shamt;
  logic [55:0]         pc1_key;
  logic [SUBKEY_W-1:0] subkey_q, subkey_nxt;
  logic                accept, last;

  assign accept  = (state == IDLE) && bus.start;
  assign last    = (state == RUN) && (rcnt == 4'd15);
  assign pc1_key = pc1(bus.key);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // On accept the first subkey is built straight from PC-1(key) so round 0 is ready one cycle later.
  // Decrypt round 1 uses C0/D0 unrotated, since the full encrypt schedule rotates by exactly 28.
  always_comb begin
    c_src   = c_q;
    d_src   = d_q;
    dir_src = dir_q;
    shamt   = 2'd0;
    if (state == IDLE) begin
      c_src   = pc1_key[55:28];
      d_src   = pc1_key[27:0];
      dir_src = bus.decrypt;
      shamt   = bus.decrypt ? 2'd0 : SHIFT_SCHED[0];
    end else if (!dir_q) begin
      shamt = SHIFT_SCHED[rcnt + 4'd1];
    end else begin
      shamt = SHIFT_SCHED[4'd15 - rcnt];
    end
    if (dir_src) begin
      c_nxt = rotr28(c_src, shamt);
      d_nxt = rotr28(d_src, shamt);
    end else begin
      c_nxt = rotl28(c_src, shamt);
      d_nxt = rotl28(d_src, shamt);
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_nxt, d_nxt}),
    .subkey (subkey_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q      <= '0;
      d_q      <= '0;
      dir_q    <= 1'b0;
      rcnt     <= '0;
      subkey_q <= '0;
    end else if (accept) begin
      c_q      <= c_nxt;
      d_q      <= d_nxt;
      dir_q    <= dir_src;
      rcnt     <= '0;
      subkey_q <= subkey_nxt;
    end else if (state == RUN) begin
      rcnt <= rcnt + 4'd1;
      if (!last) begin
        c_q      <= c_nxt;
        d_q      <= d_nxt;
        subkey_q <= subkey_nxt;
      end
    end
  end

  assign bus.subkey    = subkey_q;
  assign bus.round     = {1'b0, rcnt};
  assign bus.key_valid = (state == RUN);
  assign bus.done      = last;
  assign bus.busy      = (state == RUN);

endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - scoreboard bench for des_key_sched against a table-driven DES key model
module tb_des_key_sched;
  import des_key_sched_pkg::*;

  localparam int PC1_REF [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_REF [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam logic [63:0] PARITY_BITS = 64'h0101010101010101;
  localparam logic [63:0] KAT_KEY     = 64'h133457799BBCDFF1;

  typedef struct packed {
    logic [47:0] sk;
    logic [4:0]  rnd;
    logic        dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_sched_if intf ();

  des_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          kv_count = 0;
  exp_t        exp_q[$];
  logic [47:0] ref_ks [16];
  logic [47:0] obs [16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  function automatic logic [27:0] rot_left(input logic [27:0] x, input int n);
    logic [55:0] w;
    w = {x, x} << n;
    return w[55:28];
  endfunction

  // Reference: subkey r is PC-2 of C0/D0 rotated left by the cumulative shift count.
  task automatic build_ref(input logic [63:0] k);
    logic [27:0] c0, d0;
    logic [55:0] cd;
    int          tot;
    for (int i = 0; i < 28; i++) begin
      c0[27 - i] = k[64 - PC1_REF[i]];
      d0[27 - i] = k[64 - PC1_REF[28 + i]];
    end
    tot = 0;
    for (int r = 1; r <= NROUNDS; r++) begin
      tot += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      cd = {rot_left(c0, tot), rot_left(d0, tot)};
      for (int j = 0; j < 48; j++) ref_ks[r - 1][47 - j] = cd[56 - PC2_REF[j]];
    end
  endtask

  task automatic push_run(input logic [63:0] k, input logic dec);
    exp_t e;
    build_ref(k);
    for (int r = 0; r < NROUNDS; r++) begin
      e.sk  = dec ? ref_ks[NROUNDS - 1 - r] : ref_ks[r];
      e.rnd = 5'(r);
      e.dn  = (r == NROUNDS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [63:0] model_key, input logic dec, input logic [63:0] drive_key);
    push_run(model_key, dec);
    kv_count     = 0;
    intf.key     = drive_key;
    intf.decrypt = dec;
    intf.start   = 1'b1;
    tick();
    intf.start   = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40; n++) begin
      if (intf.done === 1'b1) begin
        tick();
        return;
      end
      tick();
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_round(input int r);
    for (int n = 0; n < 40; n++) begin
      if (intf.key_valid === 1'b1 && intf.round == 5'(r)) return;
      tick();
    end
    chk("round_timeout", 64'd0, 64'(r));
  endtask

  task automatic end_run(input string tag);
    chk({tag, "_kv_count"}, 64'(kv_count), 64'd16);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {intf.subkey, 11'(intf.round), intf.key_valid, intf.done, intf.busy}, 64'd0);
  endtask

  // Monitor: pops one expected entry for every cycle the DUT presents a subkey.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (intf.key_valid === 1'b1) begin
        kv_count++;
        obs[intf.round[3:0]] = intf.subkey;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid round=%0d subkey=%h", intf.round, intf.subkey);
        end else begin
          e = exp_q.pop_front();
          if (intf.subkey !== e.sk || intf.round !== e.rnd || intf.done !== e.dn || intf.busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_round got sk=%h rnd=%0d done=%b busy=%b expected sk=%h rnd=%0d done=%b busy=1",
                     intf.subkey, intf.round, intf.done, intf.busy, e.sk, e.rnd, e.dn);
          end
        end
      end else if (rst === 1'b0) begin
        checks++;
        if (intf.done !== 1'b0 || intf.busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_flags got done=%b busy=%b expected 0 0", intf.done, intf.busy);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k, k2, pm;
    rst          = 1'b1;
    intf.start   = 1'b0;
    intf.decrypt = 1'b0;
    intf.key     = '0;
    repeat (3) tick();
    chk_outputs_zero("reset_outputs");
    rst = 1'b0;
    tick();
    chk_outputs_zero("post_reset_outputs");

    start_run(KAT_KEY, 1'b0, KAT_KEY);
    wait_done();
    chk("kat_enc_r0", 64'(obs[0]), 64'h1B02EFFC7072);
    chk("kat_enc_r1", 64'(obs[1]), 64'h79AED9DBC9E5);
    chk("kat_enc_r15", 64'(obs[15]), 64'hCB3D8B0E17F5);
    end_run("kat_enc");

    start_run(KAT_KEY, 1'b1, KAT_KEY);
    wait_done();
    chk("kat_dec_r0", 64'(obs[0]), 64'hCB3D8B0E17F5);
    chk("kat_dec_r1", 64'(obs[1]), 64'hBF918D3D3F0A);
    chk("kat_dec_r15", 64'(obs[15]), 64'h1B02EFFC7072);
    end_run("kat_dec");

    // Random keys, both directions; decrypt run drives the key with random parity bits flipped.
    for (int i = 0; i < 200; i++) begin
      k  = {$urandom(), $urandom()};
      pm = {$urandom(), $urandom()} & PARITY_BITS;
      start_run(k, 1'b0, k);
      wait_done();
      end_run("rand_enc");
      start_run(k, 1'b1, k ^ pm);
      wait_done();
      end_run("rand_dec_parity");
    end

    // Start pulses and input churn during a run must be ignored, including start in the done cycle.
    k = {$urandom(), $urandom()};
    start_run(k, 1'b0, k);
    wait_round(3);
    intf.start   = 1'b1;
    intf.key     = {$urandom(), $urandom()};
    intf.decrypt = 1'b1;
    tick();
    intf.start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      intf.key     = {$urandom(), $urandom()};
      intf.decrypt = ~intf.decrypt;
      tick();
    end
    wait_round(15);
    intf.start = 1'b1;
    intf.key   = {$urandom(), $urandom()};
    tick();
    intf.start = 1'b0;
    chk("start_in_done_ignored", {62'd0, intf.key_valid, intf.busy}, 64'd0);
    end_run("interfere");
    k2 = {$urandom(), $urandom()};
    start_run(k2, 1'b1, k2);
    wait_done();
    end_run("restart_after_idle");

    // Reset during round 7 abandons the schedule; rst also beats a simultaneous start.
    k = {$urandom(), $urandom()};
    start_run(k, 1'b0, k);
    wait_round(7);
    rst = 1'b1;
    tick();
    chk_outputs_zero("mid_run_reset");
    exp_q.delete();
    intf.start = 1'b1;
    tick();
    chk_outputs_zero("rst_beats_start");
    rst        = 1'b0;
    intf.start = 1'b0;
    tick();
    k2 = {$urandom(), $urandom()};
    start_run(k2, 1'b0, k2);
    chk("after_reset_first", {15'd0, intf.key_valid, 11'(intf.round), 37'(0)} | 64'(intf.subkey),
        {15'd0, 1'b1, 11'd0, 37'(0)} | 64'(ref_ks[0]));
    wait_done();
    end_run("after_reset");

    // Back-to-back schedules with the minimum one-cycle gap, alternating direction.
    for (int i = 0; i < 6; i++) begin
      k = {$urandom(), $urandom()};
      start_run(k, 1'(i % 2), k);
      wait_done();
      end_run("b2b");
    end

    repeat (3) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
